// File: rtl/regfile_sequencer.sv
// regfile_sequencer: one-command-at-a-time initiator for a 2-entry 8-bit
// register file. It writes the operands to A and B, reads them back,
// computes ADD/SUB/AND/XOR on the readback values, writes the result to A,
// and presents the result with a readback-integrity flag.
// Ports:
//   sysclk, reset          clock, async active-high reset
//   cmd_valid/ready        command handshake; cmd_op, cmd_a, cmd_b
//   res_valid/ready        result handshake; res_data, res_carry, res_err
//   rf_w, rf_rw, rf_wsel   register file write data / enable / target
//   rf_rsel                register file read selects
//   rf_read0, rf_read1     registered read ports of the register file
module regfile_sequencer (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       res_err,
  output logic [7:0] rf_w,
  output logic       rf_rw,
  output logic       rf_wsel,
  output logic [1:0] rf_rsel,
  input  logic [7:0] rf_read0,
  input  logic [7:0] rf_read1
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    WR_B = 3'd2,
    RD   = 3'd3,
    CAP  = 3'd4,
    WB   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  state_t     state_q;
  logic [1:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] data_q;
  logic       carry_q;
  logic       err_q;

  logic [7:0] alu_data_d;
  logic       alu_carry_d;
  logic [8:0] sum;
  logic [8:0] diff;

  // The result is computed from what the register file returned,
  // not from the latched operands; bit 8 of diff is the borrow.
  assign sum  = {1'b0, rf_read0} + {1'b0, rf_read1};
  assign diff = {1'b0, rf_read0} - {1'b0, rf_read1};

  always_comb begin
    alu_data_d  = 8'h00;
    alu_carry_d = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_data_d  = sum[7:0];
        alu_carry_d = sum[8];
      end
      OP_SUB: begin
        alu_data_d  = diff[7:0];
        alu_carry_d = diff[8];
      end
      OP_AND: alu_data_d = rf_read0 & rf_read1;
      OP_XOR: alu_data_d = rf_read0 ^ rf_read1;
      default: begin
        alu_data_d  = 8'h00;
        alu_carry_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      data_q  <= 8'h00;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            state_q <= WR_A;
          end
        end
        WR_A: state_q <= WR_B;
        WR_B: state_q <= RD;
        RD:   state_q <= CAP;
        CAP: begin
          data_q  <= alu_data_d;
          carry_q <= alu_carry_d;
          err_q   <= (rf_read0 != a_q) | (rf_read1 != b_q);
          state_q <= WB;
        end
        WB:   state_q <= DONE;
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Register file bus is decoded from the state register alone.
  always_comb begin
    rf_rw   = 1'b0;
    rf_wsel = 1'b0;
    rf_rsel = 2'b01;
    rf_w    = 8'h00;
    unique case (state_q)
      WR_A: begin
        rf_rw = 1'b1;
        rf_w  = a_q;
      end
      WR_B: begin
        rf_rw   = 1'b1;
        rf_wsel = 1'b1;
        rf_w    = b_q;
      end
      WB: begin
        rf_rw = 1'b1;
        rf_w  = data_q;
      end
      default: begin
        rf_rw   = 1'b0;
        rf_wsel = 1'b0;
        rf_rsel = 2'b01;
        rf_w    = 8'h00;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign res_valid = (state_q == DONE);
  assign res_data  = data_q;
  assign res_carry = carry_q;
  assign res_err   = err_q;

endmodule
